unidade_controle_multiciclo: RTL

- Multicycle main control FSM for the RV32I datapath. It sits directly upstream of controlador_ula and supplies its op_ula input.
- Per instruction, it sequences fetch, decode, execute, memory and writeback. It drives all datapath mux, write-enable and memory-request strobes, with a wait handshake to the shared instruction/data memory.
- Supported opcodes: R-type add/sub/and/or, addi, lw, sw, beq. Any other opcode traps to a sticky error state.

---
 rtl/unidade_controle_multiciclo_if.sv | 40 ++++
 rtl/unidade_controle_multiciclo.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_multiciclo_if.sv
// Control bus between the multicycle main control FSM and the RV32I datapath.
//   master : the control unit. It receives opcode, zero and mem_pronto, and
//            drives every mux select, strobe and status signal.
//   slave  : the datapath and memory side, with the opposite directions.
// LARGURA_CONT sets the width of the retired-instruction counter.
interface unidade_controle_multiciclo_if #(
  parameter int LARGURA_CONT = 32
);
  logic [6:0]              opcode;
  logic                    zero;
  logic                    mem_pronto;
  logic [1:0]              op_ula;
  logic [1:0]              ula_fonte_a;
  logic [1:0]              ula_fonte_b;
  logic                    iord;
  logic                    mem_leitura;
  logic                    mem_escrita;
  logic                    ir_escrita;
  logic                    pc_escrita;
  logic                    pc_fonte;
  logic                    reg_escrita;
  logic                    mem_para_reg;
  logic                    erro;
  logic [3:0]              estado;
  logic [LARGURA_CONT-1:0] contador_instr;

  modport master (
    input  opcode, zero, mem_pronto,
    output op_ula, ula_fonte_a, ula_fonte_b, iord, mem_leitura, mem_escrita,
           ir_escrita, pc_escrita, pc_fonte, reg_escrita, mem_para_reg,
           erro, estado, contador_instr
  );

  modport slave (
    output opcode, zero, mem_pronto,
    input  op_ula, ula_fonte_a, ula_fonte_b, iord, mem_leitura, mem_escrita,
           ir_escrita, pc_escrita, pc_fonte, reg_escrita, mem_para_reg,
           erro, estado, contador_instr
  );
endinterface

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle main control FSM for the RV32I datapath. It supports add, sub,
// and, or, addi, lw, sw and beq. Any other opcode traps to a sticky ERRO
// state.
// Ports:
//   clk : rising-edge clock.
//   rst : asynchronous, active-high reset.
//   bus : control bus, master side. It carries:
//         - inputs opcode, zero and mem_pronto;
//         - the datapath selects and strobes;
//         - erro, the estado debug encoding, and the retired-instruction
//           counter.
// While rst is high, every output is held at 0, whatever the state register
// holds.
module unidade_controle_multiciclo #(
  parameter int LARGURA_CONT = 32
) (
  input  logic clk,
  input  logic rst,
  unidade_controle_multiciclo_if.master bus
);

  typedef enum logic [3:0] {
    BUSCA       = 4'd0,
    DECODIFICA  = 4'd1,
    EXEC_R      = 4'd2,
    EXEC_I      = 4'd3,
    CALC_END    = 4'd4,
    EXEC_BEQ    = 4'd5,
    MEM_LW      = 4'd6,
    MEM_SW      = 4'd7,
    ESCRITA_ULA = 4'd8,
    ESCRITA_MEM = 4'd9,
    ERRO        = 4'd15
  } estado_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  estado_t                 estado_q, estado_d;
  logic [LARGURA_CONT-1:0] cont_q;
  logic                    retira;

  logic [1:0] op_ula, fonte_a, fonte_b;
  logic       iord, mem_rd, mem_wr, ir_wr, pc_wr, pc_fonte, reg_wr, mem_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= BUSCA;
      cont_q   <= '0;
    end else begin
      estado_q <= estado_d;
      if (retira) cont_q <= cont_q + 1'b1;
    end
  end

  always_comb begin
    estado_d = estado_q;
    retira   = 1'b0;
    op_ula   = 2'b00;
    fonte_a  = 2'b00;
    fonte_b  = 2'b00;
    iord     = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    ir_wr    = 1'b0;
    pc_wr    = 1'b0;
    pc_fonte = 1'b0;
    reg_wr   = 1'b0;
    mem_reg  = 1'b0;
    case (estado_q)
      BUSCA: begin
        // The PC+4 increment and the IR load both happen only on the
        // cycle the memory delivers the instruction.
        mem_rd  = 1'b1;
        fonte_b = 2'b01;
        ir_wr   = bus.mem_pronto;
        pc_wr   = bus.mem_pronto;
        if (bus.mem_pronto) estado_d = DECODIFICA;
      end
      DECODIFICA: begin
        // Computes pc_antigo + imm ahead of time, so beq can use it later.
        fonte_a = 2'b01;
        fonte_b = 2'b10;
        case (bus.opcode)
          OP_R:         estado_d = EXEC_R;
          OP_I:         estado_d = EXEC_I;
          OP_LW, OP_SW: estado_d = CALC_END;
          OP_BEQ:       estado_d = EXEC_BEQ;
          default:      estado_d = ERRO;
        endcase
      end
      EXEC_R: begin
        fonte_a  = 2'b10;
        op_ula   = 2'b10;
        estado_d = ESCRITA_ULA;
      end
      EXEC_I: begin
        fonte_a  = 2'b10;
        fonte_b  = 2'b10;
        estado_d = ESCRITA_ULA;
      end
      CALC_END: begin
        fonte_a  = 2'b10;
        fonte_b  = 2'b10;
        estado_d = (bus.opcode == OP_LW) ? MEM_LW : MEM_SW;
      end
      EXEC_BEQ: begin
        fonte_a  = 2'b10;
        op_ula   = 2'b01;
        pc_fonte = 1'b1;
        pc_wr    = bus.zero;
        retira   = 1'b1;
        estado_d = BUSCA;
      end
      MEM_LW: begin
        mem_rd = 1'b1;
        iord   = 1'b1;
        if (bus.mem_pronto) estado_d = ESCRITA_MEM;
      end
      MEM_SW: begin
        mem_wr = 1'b1;
        iord   = 1'b1;
        if (bus.mem_pronto) begin
          retira   = 1'b1;
          estado_d = BUSCA;
        end
      end
      ESCRITA_ULA: begin
        reg_wr   = 1'b1;
        retira   = 1'b1;
        estado_d = BUSCA;
      end
      ESCRITA_MEM: begin
        reg_wr   = 1'b1;
        mem_reg  = 1'b1;
        retira   = 1'b1;
        estado_d = BUSCA;
      end
      ERRO:    estado_d = ERRO;
      default: estado_d = ERRO;
    endcase
  end

  // The rst gate drops any pending memory request at once, without waiting
  // for a clock edge.
  assign bus.op_ula         = rst ? 2'b00 : op_ula;
  assign bus.ula_fonte_a    = rst ? 2'b00 : fonte_a;
  assign bus.ula_fonte_b    = rst ? 2'b00 : fonte_b;
  assign bus.iord           = ~rst & iord;
  assign bus.mem_leitura    = ~rst & mem_rd;
  assign bus.mem_escrita    = ~rst & mem_wr;
  assign bus.ir_escrita     = ~rst & ir_wr;
  assign bus.pc_escrita     = ~rst & pc_wr;
  assign bus.pc_fonte       = ~rst & pc_fonte;
  assign bus.reg_escrita    = ~rst & reg_wr;
  assign bus.mem_para_reg   = ~rst & mem_reg;
  assign bus.erro           = ~rst & (estado_q == ERRO);
  assign bus.estado         = rst ? 4'd0 : estado_q;
  assign bus.contador_instr = rst ? '0 : cont_q;

endmodule
